flash_address_controller: RTL and testbench

Generates the 32-bit-word flash read address for audio playback and advances it each time the flash reader signals `address_change`. Sits directly upstream of the flash reader: its `flsh_address` drives the flash address bus while the reader issues reads, and the reader's `address_change` pulse consumes one word. Keyboard commands select playback direction and request a restart, applied at word boundaries so an in-flight read is never disturbed.

---
 rtl/flash_address_controller.sv | 150 +++++++++++++++
 tb/tb_flash_address_controller.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_address_controller.sv
// flash_address_controller: produces the flash word address for audio playback and steps it
// on each address_change pulse from the flash reader. Keyboard commands pick the direction and
// request restarts; both take effect only on word boundaries.
//
// Optional feature macro: ADDR_LOOP_EN
//   defined   -> boundary steps wrap to the opposite end of the region, done tied 0
//   undefined -> boundary steps hold the address and raise done until restart/reversal

module flash_address_controller #(
  parameter int unsigned           ADDR_W     = 23,
  parameter logic [ADDR_W-1:0]     START_ADDR = ADDR_W'(23'h000000),
  parameter logic [ADDR_W-1:0]     END_ADDR   = ADDR_W'(23'h07FFFF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              address_change,
  input  logic              kybrd_forward,
  input  logic              kybrd_backward,
  input  logic              kybrd_restart,
  output logic [ADDR_W-1:0] flsh_address,
  output logic              direction,
  output logic              restart_pending,
  output logic              wrapped,
  output logic              done
);

  localparam logic [ADDR_W-1:0] Span = END_ADDR - START_ADDR;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              dir_q, dir_d;
  logic              pending_q, pending_d;
  logic              wrapped_q, wrapped_d;
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              at_boundary;

`ifndef ADDR_LOOP_EN
  logic              done_q, done_d;
  logic              blocked;
`endif

  // Range check via offset from the region start avoids constant compares when START is 0.
  always_comb begin
    offset      = addr_q - START_ADDR;
    in_range    = (offset <= Span);
    at_boundary = dir_d ? (addr_q == START_ADDR) : (addr_q == END_ADDR);
  end

`ifndef ADDR_LOOP_EN
  // Stepping is frozen at the boundary unless the same cycle reverses direction.
  always_comb begin
    blocked = done_q && (dir_d == dir_q);
  end
`endif

  // Next-state: direction, restart bookkeeping and the address step.
  always_comb begin
    dir_d     = dir_q;
    addr_d    = addr_q;
    pending_d = pending_q;
    wrapped_d = 1'b0;
`ifndef ADDR_LOOP_EN
    done_d    = done_q;
`endif

    // Simultaneous forward and backward cancel out.
    if (kybrd_forward && !kybrd_backward) begin
      dir_d = 1'b0;
    end else if (kybrd_backward && !kybrd_forward) begin
      dir_d = 1'b1;
    end

`ifndef ADDR_LOOP_EN
    // Reversing away from the boundary releases the hold.
    if (done_q && (dir_d != dir_q)) begin
      done_d = 1'b0;
    end
`endif

    if (address_change) begin
      if (pending_q || kybrd_restart) begin
        addr_d    = dir_d ? END_ADDR : START_ADDR;
        pending_d = 1'b0;
`ifndef ADDR_LOOP_EN
        done_d    = 1'b0;
`endif
      end else if (!in_range) begin
        addr_d = START_ADDR;
`ifdef ADDR_LOOP_EN
      end else if (at_boundary) begin
        addr_d    = dir_d ? END_ADDR : START_ADDR;
        wrapped_d = 1'b1;
      end else begin
        addr_d = dir_d ? (addr_q - 1'b1) : (addr_q + 1'b1);
      end
`else
      end else if (!blocked) begin
        if (at_boundary) begin
          done_d    = 1'b1;
          wrapped_d = 1'b1;
        end else begin
          addr_d = dir_d ? (addr_q - 1'b1) : (addr_q + 1'b1);
        end
      end
`endif
    end else if (kybrd_restart) begin
      pending_d = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= START_ADDR;
      dir_q     <= 1'b0;
      pending_q <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      dir_q     <= dir_d;
      pending_q <= pending_d;
      wrapped_q <= wrapped_d;
    end
  end

`ifndef ADDR_LOOP_EN
  // Boundary hold flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
    end else begin
      done_q <= done_d;
    end
  end
`endif

  // Outputs come straight from registers.
  always_comb begin
    flsh_address    = addr_q;
    direction       = dir_q;
    restart_pending = pending_q;
    wrapped         = wrapped_q;
`ifdef ADDR_LOOP_EN
    done            = 1'b0;
`else
    done            = done_q;
`endif
  end

endmodule

// File: tb/tb_flash_address_controller.sv
// Directed bench for flash_address_controller with an 8-bit region 0x10..0x13.
// Follows the same ADDR_LOOP_EN macro as the design to pick boundary expectations.

module tb_flash_address_controller;

  logic       clk;
  logic       rst_n;
  logic       address_change;
  logic       kybrd_forward;
  logic       kybrd_backward;
  logic       kybrd_restart;
  logic [7:0] flsh_address;
  logic       direction;
  logic       restart_pending;
  logic       wrapped;
  logic       done;

  int checks;
  int errors;

  flash_address_controller #(
    .ADDR_W    (8),
    .START_ADDR(8'h10),
    .END_ADDR  (8'h13)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address_change (address_change),
    .kybrd_forward  (kybrd_forward),
    .kybrd_backward (kybrd_backward),
    .kybrd_restart  (kybrd_restart),
    .flsh_address   (flsh_address),
    .direction      (direction),
    .restart_pending(restart_pending),
    .wrapped        (wrapped),
    .done           (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs between falling edges; returns at the next falling edge so the
  // outputs of the intervening rising edge are settled.
  task automatic pulse(input logic ac, input logic fwd, input logic bwd, input logic rst);
    @(negedge clk);
    address_change = ac;
    kybrd_forward  = fwd;
    kybrd_backward = bwd;
    kybrd_restart  = rst;
    @(negedge clk);
    address_change = 1'b0;
    kybrd_forward  = 1'b0;
    kybrd_backward = 1'b0;
    kybrd_restart  = 1'b0;
  endtask

  task automatic test_reset;
    address_change = 1'b0;
    kybrd_forward  = 1'b0;
    kybrd_backward = 1'b0;
    kybrd_restart  = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({flsh_address, direction, restart_pending, wrapped, done} !== {8'h10, 4'b0000}) begin
      errors++;
      $display("FAIL reset: got addr=%h dir=%b pend=%b wrap=%b done=%b, want addr=10 flags 0",
               flsh_address, direction, restart_pending, wrapped, done);
    end
  endtask

  task automatic test_forward;
    logic [7:0] exp_addr [3];
    exp_addr[0] = 8'h11;
    exp_addr[1] = 8'h12;
    exp_addr[2] = 8'h13;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (flsh_address !== exp_addr[i]) begin
        errors++;
        $display("FAIL forward_step%0d: got %h want %h", i, flsh_address, exp_addr[i]);
      end
    end
    // Keyboard commands alone must not move the address.
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (flsh_address !== 8'h13) begin
      errors++;
      $display("FAIL kbd_no_move: got %h want 13", flsh_address);
    end
  endtask

`ifdef ADDR_LOOP_EN
  task automatic test_boundary;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({flsh_address, wrapped, done} !== {8'h10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_fwd: got addr=%h wrap=%b done=%b want 10 1 0",
               flsh_address, wrapped, done);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({flsh_address, direction, wrapped} !== {8'h10, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_pulse_end: got addr=%h dir=%b wrap=%b want 10 1 0",
               flsh_address, direction, wrapped);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({flsh_address, wrapped} !== {8'h13, 1'b1}) begin
      errors++;
      $display("FAIL wrap_bwd: got addr=%h wrap=%b want 13 1", flsh_address, wrapped);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({flsh_address, wrapped} !== {8'h12, 1'b0}) begin
      errors++;
      $display("FAIL step_bwd: got addr=%h wrap=%b want 12 0", flsh_address, wrapped);
    end
  endtask
`else
  task automatic test_boundary;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({flsh_address, wrapped, done} !== {8'h13, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL hold_first: got addr=%h wrap=%b done=%b want 13 1 1",
               flsh_address, wrapped, done);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({flsh_address, wrapped, done} !== {8'h13, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL hold_second: got addr=%h wrap=%b done=%b want 13 0 1",
               flsh_address, wrapped, done);
    end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({flsh_address, direction, done} !== {8'h13, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reverse_release: got addr=%h dir=%b done=%b want 13 1 0",
               flsh_address, direction, done);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({flsh_address, done} !== {8'h12, 1'b0}) begin
      errors++;
      $display("FAIL step_after_release: got addr=%h done=%b want 12 0", flsh_address, done);
    end
  endtask
`endif

  // Enters at 0x12 going backward; restarts forward from there.
  task automatic test_restart_pending;
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({flsh_address, direction, restart_pending} !== {8'h12, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL restart_pend: got addr=%h dir=%b pend=%b want 12 0 1",
               flsh_address, direction, restart_pending);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({flsh_address, restart_pending, wrapped} !== {8'h10, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restart_apply: got addr=%h pend=%b wrap=%b want 10 0 0",
               flsh_address, restart_pending, wrapped);
    end
  endtask

  task automatic test_restart_same_cycle;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    // Both direction commands together must leave direction unchanged.
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if ({flsh_address, direction} !== {8'h12, 1'b1}) begin
      errors++;
      $display("FAIL dir_both: got addr=%h dir=%b want 12 1", flsh_address, direction);
    end
    pulse(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({flsh_address, restart_pending, wrapped} !== {8'h13, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL restart_same: got addr=%h pend=%b wrap=%b want 13 0 0",
               flsh_address, restart_pending, wrapped);
    end
    pulse(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({flsh_address, restart_pending} !== {8'h13, 1'b0}) begin
      errors++;
      $display("FAIL restart_same_idle: got addr=%h pend=%b want 13 0",
               flsh_address, restart_pending);
    end
  endtask

  task automatic test_async_reset;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (flsh_address !== 8'h12) begin
      errors++;
      $display("FAIL pre_reset: got %h want 12", flsh_address);
    end
    // Leave a pending restart behind so reset has something to discard.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({flsh_address, direction, restart_pending, wrapped, done} !== {8'h10, 4'b0000}) begin
      errors++;
      $display("FAIL async_reset: got addr=%h dir=%b pend=%b wrap=%b done=%b want 10 0 0 0 0",
               flsh_address, direction, restart_pending, wrapped, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    address_change = 1'b1;
    repeat (2) @(negedge clk);
    address_change = 1'b0;
    checks++;
    if ({flsh_address, restart_pending} !== {8'h12, 1'b0}) begin
      errors++;
      $display("FAIL back_to_back: got addr=%h pend=%b want 12 0", flsh_address, restart_pending);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_forward();
    test_boundary();
    test_restart_pending();
    test_restart_same_cycle();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
